// File: rtl/l2_fwd_stall_q.sv
// Stalled coherence-forward queue: holds forwards blocked on a pending L2 request
// and replays them oldest-first per line once the blocking request index releases.
module l2_fwd_stall_q #(
    parameter int N_ENTRIES      = 4,
    parameter int REQS_BITS      = 2,
    parameter int LINE_ADDR_BITS = 26,
    parameter int MSG_BITS       = 5,
    parameter int ID_BITS        = 4,
    localparam int CNT_W         = $clog2(N_ENTRIES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_valid,
    output logic                      push_ready,
    input  logic [MSG_BITS-1:0]       push_msg,
    input  logic [LINE_ADDR_BITS-1:0] push_line_addr,
    input  logic [ID_BITS-1:0]        push_req_id,
    input  logic [REQS_BITS-1:0]      push_reqs_i,
    input  logic                      release_valid,
    input  logic [REQS_BITS-1:0]      release_reqs_i,
    output logic                      pop_valid,
    input  logic                      pop_ready,
    output logic [MSG_BITS-1:0]       pop_msg,
    output logic [LINE_ADDR_BITS-1:0] pop_line_addr,
    output logic [ID_BITS-1:0]        pop_req_id,
    output logic [CNT_W-1:0]          count,
    output logic                      full,
    output logic                      empty
);

    logic [N_ENTRIES-1:0]      valid_q, valid_d;
    logic [N_ENTRIES-1:0]      blocked_q, blocked_d;
    logic [MSG_BITS-1:0]       msg_q  [N_ENTRIES];
    logic [MSG_BITS-1:0]       msg_d  [N_ENTRIES];
    logic [LINE_ADDR_BITS-1:0] line_q [N_ENTRIES];
    logic [LINE_ADDR_BITS-1:0] line_d [N_ENTRIES];
    logic [ID_BITS-1:0]        id_q   [N_ENTRIES];
    logic [ID_BITS-1:0]        id_d   [N_ENTRIES];
    logic [REQS_BITS-1:0]      reqs_q [N_ENTRIES];
    logic [REQS_BITS-1:0]      reqs_d [N_ENTRIES];
    // older_q[i][j] set when entry j arrived before entry i
    logic [N_ENTRIES-1:0]      older_q [N_ENTRIES];
    logic [N_ENTRIES-1:0]      older_d [N_ENTRIES];
    logic [CNT_W-1:0]          count_q, count_d;

    logic [N_ENTRIES-1:0]      same_line_older;
    logic [N_ENTRIES-1:0]      eligible;
    logic [N_ENTRIES-1:0]      sel_oh;
    logic [N_ENTRIES-1:0]      alloc_oh;
    logic [N_ENTRIES-1:0]      pop_mask;
    logic                      push_fire;
    logic                      pop_fire;
    logic                      push_unblocked;

    assign count      = count_q;
    assign full       = (count_q == CNT_W'(N_ENTRIES));
    assign empty      = (count_q == '0);
    assign push_ready = !full;

    assign push_fire      = push_valid && push_ready;
    assign pop_fire       = pop_valid && pop_ready;
    assign push_unblocked = release_valid && (release_reqs_i == push_reqs_i);
    assign pop_mask       = {N_ENTRIES{pop_fire}} & sel_oh;

    // Lowest clear bit of valid_q; a slot popped this cycle is still valid here,
    // so it is never handed to a same-cycle push.
    assign alloc_oh = ~valid_q & (valid_q + N_ENTRIES'(1));

    always_comb begin
        same_line_older = '0;
        eligible        = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            for (int j = 0; j < N_ENTRIES; j++) begin
                if (valid_q[j] && older_q[e][j] && (line_q[j] == line_q[e])) begin
                    same_line_older[e] = 1'b1;
                end
            end
            eligible[e] = valid_q[e] && !blocked_q[e] && !same_line_older[e];
        end
    end

    // Age order is total over valid entries, so at most one eligible entry
    // has no older eligible peer.
    always_comb begin
        sel_oh = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            sel_oh[e] = eligible[e] && ((eligible & older_q[e]) == '0);
        end
    end

    always_comb begin
        pop_valid     = |eligible;
        pop_msg       = '0;
        pop_line_addr = '0;
        pop_req_id    = '0;
        for (int e = 0; e < N_ENTRIES; e++) begin
            if (sel_oh[e]) begin
                pop_msg       = pop_msg | msg_q[e];
                pop_line_addr = pop_line_addr | line_q[e];
                pop_req_id    = pop_req_id | id_q[e];
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        blocked_d = blocked_q;
        for (int i = 0; i < N_ENTRIES; i++) begin
            msg_d[i]   = msg_q[i];
            line_d[i]  = line_q[i];
            id_d[i]    = id_q[i];
            reqs_d[i]  = reqs_q[i];
            older_d[i] = older_q[i];
        end

        valid_d = valid_d & ~pop_mask;
        for (int i = 0; i < N_ENTRIES; i++) begin
            older_d[i] = older_d[i] & ~pop_mask;
            if (pop_mask[i]) begin
                older_d[i] = '0;
            end
        end

        if (release_valid) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (valid_q[i] && (reqs_q[i] == release_reqs_i)) begin
                    blocked_d[i] = 1'b0;
                end
            end
        end

        if (push_fire) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                if (alloc_oh[i]) begin
                    valid_d[i]   = 1'b1;
                    blocked_d[i] = !push_unblocked;
                    msg_d[i]     = push_msg;
                    line_d[i]    = push_line_addr;
                    id_d[i]      = push_req_id;
                    reqs_d[i]    = push_reqs_i;
                    older_d[i]   = valid_q & ~pop_mask;
                end
            end
            for (int j = 0; j < N_ENTRIES; j++) begin
                for (int i = 0; i < N_ENTRIES; i++) begin
                    if (alloc_oh[i]) begin
                        older_d[j][i] = 1'b0;
                    end
                end
            end
        end

        count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            blocked_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < N_ENTRIES; i++) begin
                msg_q[i]   <= '0;
                line_q[i]  <= '0;
                id_q[i]    <= '0;
                reqs_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            blocked_q <= blocked_d;
            count_q   <= count_d;
            for (int i = 0; i < N_ENTRIES; i++) begin
                msg_q[i]   <= msg_d[i];
                line_q[i]  <= line_d[i];
                id_q[i]    <= id_d[i];
                reqs_q[i]  <= reqs_d[i];
                older_q[i] <= older_d[i];
            end
        end
    end

endmodule

// File: tb/tb_l2_fwd_stall_q.sv
// Bench for l2_fwd_stall_q: arrival-ordered queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_l2_fwd_stall_q;

    localparam int N = 4;
    localparam logic [4:0] FWD_GETS = 5'h04;
    localparam logic [4:0] FWD_GETM = 5'h05;
    localparam logic [4:0] FWD_INV  = 5'h06;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        push_valid = 1'b0;
    logic        push_ready;
    logic [4:0]  push_msg = '0;
    logic [25:0] push_line_addr = '0;
    logic [3:0]  push_req_id = '0;
    logic [1:0]  push_reqs_i = '0;
    logic        release_valid = 1'b0;
    logic [1:0]  release_reqs_i = '0;
    logic        pop_valid;
    logic        pop_ready = 1'b0;
    logic [4:0]  pop_msg;
    logic [25:0] pop_line_addr;
    logic [3:0]  pop_req_id;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    l2_fwd_stall_q dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_msg(push_msg),
        .push_line_addr(push_line_addr), .push_req_id(push_req_id), .push_reqs_i(push_reqs_i),
        .release_valid(release_valid), .release_reqs_i(release_reqs_i),
        .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_msg(pop_msg),
        .pop_line_addr(pop_line_addr), .pop_req_id(pop_req_id),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [4:0]  msg;
        logic [25:0] addr;
        logic [3:0]  id;
        logic [1:0]  reqs;
        bit          blocked;
    } ent_t;

    ent_t q[$];

    // First entry in arrival order that is unblocked and has no earlier entry on its line.
    function automatic int exp_sel();
        for (int k = 0; k < q.size(); k++) begin
            bit shadowed = 1'b0;
            for (int m = 0; m < k; m++) begin
                if (q[m].addr == q[k].addr) shadowed = 1'b1;
            end
            if (!q[k].blocked && !shadowed) return k;
        end
        return -1;
    endfunction

    int m_sel;
    bit m_pop;
    bit m_push;
    ent_t m_new;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
        end else begin
            m_sel  = exp_sel();
            m_pop  = (m_sel >= 0) && pop_ready;
            m_push = push_valid && (q.size() < N);
            if (m_pop) q.delete(m_sel);
            if (release_valid) begin
                for (int k = 0; k < q.size(); k++) begin
                    if (q[k].reqs == release_reqs_i) q[k].blocked = 1'b0;
                end
            end
            if (m_push) begin
                m_new.msg     = push_msg;
                m_new.addr    = push_line_addr;
                m_new.id      = push_req_id;
                m_new.reqs    = push_reqs_i;
                m_new.blocked = !(release_valid && release_reqs_i == push_reqs_i);
                q.push_back(m_new);
            end
        end
    end

    int c_sel;

    always @(negedge clk) begin
        if (rst) begin
            c_sel = exp_sel();
            chk("pop_valid", 32'(pop_valid), 32'(c_sel >= 0));
            if (c_sel >= 0) begin
                chk("pop_msg", 32'(pop_msg), 32'(q[c_sel].msg));
                chk("pop_line_addr", 32'(pop_line_addr), 32'(q[c_sel].addr));
                chk("pop_req_id", 32'(pop_req_id), 32'(q[c_sel].id));
            end else begin
                chk("pop_fields_zero", 32'({pop_msg, pop_line_addr, pop_req_id}), 32'd0);
            end
            chk("count", 32'(count), 32'(q.size()));
            chk("full", 32'(full), 32'(q.size() == N));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("push_ready_not_full", 32'(push_ready), 32'(q.size() != N));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        push_valid    = 1'b0;
        release_valid = 1'b0;
        pop_ready     = 1'b0;
    endtask

    task automatic set_push(input logic [4:0] m, input logic [25:0] a, input logic [3:0] id,
                            input logic [1:0] r);
        push_valid     = 1'b1;
        push_msg       = m;
        push_line_addr = a;
        push_req_id    = id;
        push_reqs_i    = r;
    endtask

    task automatic set_rel(input logic [1:0] r);
        release_valid  = 1'b1;
        release_reqs_i = r;
    endtask

    initial begin
        #12;
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        rst = 1'b1;
        tick();

        // single forward released by its request index
        set_push(FWD_GETS, 26'h100, 4'd1, 2'd1); tick();
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_blocked", 32'(pop_valid), 32'd0);
        set_rel(2'd1); tick();
        chk("t1_pop_valid", 32'(pop_valid), 32'd1);
        chk("t1_addr", 32'(pop_line_addr), 32'h100);
        chk("t1_msg", 32'(pop_msg), 32'(FWD_GETS));
        pop_ready = 1'b1; tick();
        chk("t1_empty", 32'(empty), 32'd1);

        // different lines: younger released first overtakes
        set_push(FWD_GETM, 26'h200, 4'd2, 2'd0); tick();
        set_push(FWD_GETS, 26'h300, 4'd3, 2'd2); tick();
        set_rel(2'd2); tick();
        chk("t2_b_addr", 32'(pop_line_addr), 32'h300);
        pop_ready = 1'b1; tick();
        chk("t2_a_stays", 32'(pop_valid), 32'd0);
        chk("t2_count", 32'(count), 32'd1);
        set_rel(2'd0); tick();
        chk("t2_a_addr", 32'(pop_line_addr), 32'h200);
        chk("t2_a_id", 32'(pop_req_id), 32'd2);
        pop_ready = 1'b1; tick();
        chk("t2_empty", 32'(empty), 32'd1);

        // same line: younger waits behind the older blocked entry
        set_push(FWD_GETS, 26'h400, 4'd4, 2'd0); tick();
        set_push(FWD_INV,  26'h400, 4'd5, 2'd3); tick();
        set_rel(2'd3); tick();
        chk("t3_held", 32'(pop_valid), 32'd0);
        set_rel(2'd0); tick();
        chk("t3_a_id", 32'(pop_req_id), 32'd4);
        pop_ready = 1'b1; tick();
        chk("t3_b_valid", 32'(pop_valid), 32'd1);
        chk("t3_b_id", 32'(pop_req_id), 32'd5);
        chk("t3_b_msg", 32'(pop_msg), 32'(FWD_INV));
        pop_ready = 1'b1; tick();
        chk("t3_empty", 32'(empty), 32'd1);

        // full queue: pop plus push in one cycle does not admit the push
        set_push(FWD_GETS, 26'h500, 4'd6, 2'd1); tick();
        set_push(FWD_GETS, 26'h510, 4'd7, 2'd1); tick();
        set_push(FWD_GETM, 26'h520, 4'd8, 2'd2); tick();
        set_push(FWD_GETM, 26'h530, 4'd9, 2'd2); tick();
        chk("t4_full", 32'(full), 32'd1);
        chk("t4_push_ready", 32'(push_ready), 32'd0);
        set_rel(2'd1); tick();
        chk("t4_first", 32'(pop_line_addr), 32'h500);
        pop_ready = 1'b1;
        set_push(FWD_INV, 26'h540, 4'd10, 2'd0); tick();
        chk("t4_count3", 32'(count), 32'd3);
        chk("t4_ready_again", 32'(push_ready), 32'd1);
        chk("t4_next", 32'(pop_line_addr), 32'h510);
        pop_ready = 1'b1; tick();
        set_rel(2'd2); tick();
        chk("t4_third", 32'(pop_line_addr), 32'h520);
        pop_ready = 1'b1; tick();
        chk("t4_fourth", 32'(pop_line_addr), 32'h530);
        pop_ready = 1'b1; tick();
        chk("t4_empty", 32'(empty), 32'd1);

        // push coinciding with release of its own index enters unblocked
        set_push(FWD_GETM, 26'h600, 4'd11, 2'd2);
        set_rel(2'd2); tick();
        chk("t5_pop_valid", 32'(pop_valid), 32'd1);
        chk("t5_addr", 32'(pop_line_addr), 32'h600);
        pop_ready = 1'b1; tick();

        // asynchronous reset discards blocked contents
        set_push(FWD_GETS, 26'h700, 4'd12, 2'd1); tick();
        set_push(FWD_GETS, 26'h710, 4'd13, 2'd1); tick();
        chk("t6_count2", 32'(count), 32'd2);
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        #2 rst = 1'b1;
        tick();
        set_rel(2'd1); tick();
        chk("t6_no_pop", 32'(pop_valid), 32'd0);
        chk("t6_count0", 32'(count), 32'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
